// File: rtl/fifo_ctrl_param_if.sv
// Request/status bundle between a FIFO user and fifo_ctrl_param.
// The master drives the requests; the slave (the controller) drives RAM strobes and status.
interface fifo_ctrl_param_if #(
    parameter int ADDR_W = 3
);
    logic              insert;
    logic              remove;
    logic              flush;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output insert, remove, flush,
        input  wr_addr, rd_addr, ram_we, ram_re, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  insert, remove, flush,
        output wr_addr, rd_addr, ram_we, ram_re, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Single-cycle FIFO controller for an external dual-port RAM: pointers, count, flags, strobes.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow error flags.
module fifo_ctrl_param #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic               ck_i,
    input  logic               reset_n_i,
    fifo_ctrl_param_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_LEVEL);

    // Bit 0 is the empty flag, bit 1 the full flag, so the state register drives them directly.
    typedef enum logic [1:0] {
        PARTIAL = 2'b00,
        EMPTY   = 2'b01,
        FULL    = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_ok, rd_ok;

    always_comb begin
        wr_ok   = reset_n_i & bus.insert & ~bus.flush & (state_q != FULL);
        rd_ok   = reset_n_i & bus.remove & ~bus.flush & (state_q != EMPTY);
        state_d = state_q;
        wp_d    = wp_q + {{(ADDR_W-1){1'b0}}, wr_ok};
        rp_d    = rp_q + {{(ADDR_W-1){1'b0}}, rd_ok};
        cnt_d   = cnt_q;

        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        case (state_q)
            EMPTY: begin
                if (wr_ok) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (wr_ok && !rd_ok && cnt_q == CNT_FULL - CNT_ONE) begin
                    state_d = FULL;
                end else if (rd_ok && !wr_ok && cnt_q == CNT_ONE) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (rd_ok) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase

        if (bus.flush) begin
            state_d = EMPTY;
            wp_d    = '0;
            rp_d    = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge ck_i) begin
        if (!reset_n_i) begin
            state_q <= EMPTY;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Refused requests only; flush never clears these, only reset does.
    always_comb begin
        ovf_d = ovf_q | (bus.insert & ~bus.flush & (state_q == FULL) & ~rd_ok);
        unf_d = unf_q | (bus.remove & ~bus.flush & (state_q == EMPTY));
    end

    always_ff @(posedge ck_i) begin
        if (!reset_n_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.wr_addr      = wp_q;
    assign bus.rd_addr      = rp_q;
    assign bus.ram_we       = wr_ok;
    assign bus.ram_re       = rd_ok;
    assign bus.count        = cnt_q;
    assign bus.empty        = state_q[0];
    assign bus.full         = state_q[1];
    assign bus.almost_full  = (cnt_q >= AF_CNT);
    assign bus.almost_empty = (cnt_q <= AE_CNT);

    a_full_cnt: assert property (@(posedge ck_i) disable iff (!reset_n_i)
        bus.full == (cnt_q == CNT_FULL));
    a_empty_cnt: assert property (@(posedge ck_i) disable iff (!reset_n_i)
        bus.empty == (cnt_q == '0));
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Randomized and directed checks of fifo_ctrl_param against an occupancy/pointer model.
module tb_fifo_ctrl_param;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
`ifdef FIFO_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic ck = 1'b0;
    logic rn = 1'b0;
    logic ins = 1'b0, rem = 1'b0, fl = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // reference model: occupancy, pointers, sticky flags
    int m_cnt = 0, m_wp = 0, m_rp = 0;
    bit m_ov = 1'b0, m_un = 1'b0;

    always #5 ck = ~ck;

    fifo_ctrl_param_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.insert = ins;
    assign bus.remove = rem;
    assign bus.flush  = fl;

    fifo_ctrl_param #(.ADDR_W(ADDR_W), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .ck_i(ck), .reset_n_i(rn), .bus(bus)
    );

    function automatic bit exp_we();
        return rn && ins && !fl && m_cnt < DEPTH;
    endfunction

    function automatic bit exp_re();
        return rn && rem && !fl && m_cnt > 0;
    endfunction

    // {count, full, empty, almost_full, almost_empty, overflow, underflow, wr_addr, rd_addr}
    function automatic logic [15:0] expv();
        logic [3:0] c;
        logic [2:0] w, r;
        c = 4'(m_cnt);
        w = 3'(m_wp);
        r = 3'(m_rp);
        return {c, m_cnt == DEPTH, m_cnt == 0, m_cnt >= 6, m_cnt <= 1, m_ov, m_un, w, r};
    endfunction

    function automatic logic [15:0] obsv();
        return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                bus.overflow, bus.underflow, bus.wr_addr, bus.rd_addr};
    endfunction

    task automatic drive(input bit i, input bit r, input bit f, input bit n);
        @(negedge ck);
        ins = i; rem = r; fl = f; rn = n;
        #1;
    endtask

    task automatic tick();
        bit we, re;
        @(posedge ck);
        we = exp_we();
        re = exp_re();
        if (!rn) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ov = 0; m_un = 0;
        end else if (fl) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
        end else begin
            if (ERR_EN && ins && m_cnt == DEPTH && !re) m_ov = 1'b1;
            if (ERR_EN && rem && m_cnt == 0) m_un = 1'b1;
            m_wp  = (m_wp + int'(we)) % DEPTH;
            m_rp  = (m_rp + int'(re)) % DEPTH;
            m_cnt = m_cnt + int'(we) - int'(re);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0);
        checks++;
        if ({bus.ram_we, bus.ram_re} !== 2'b00) begin
            errors++; $display("FAIL reset_strobes: got %b want 00", {bus.ram_we, bus.ram_re});
        end
        tick();
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if (obsv() !== 16'b0000_0_1_0_1_0_0_000_000) begin
            errors++; $display("FAIL reset_state: got %b want %b", obsv(), 16'b0000_0_1_0_1_0_0_000_000);
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1, 0, 0, 1);
            checks++;
            if (bus.wr_addr !== 3'(k - 1) || bus.ram_we !== 1'b1) begin
                errors++; $display("FAIL fill_wr k=%0d: got addr %0d we %b want addr %0d we 1", k, bus.wr_addr, bus.ram_we, k - 1);
            end
            tick();
            checks++;
            if (bus.almost_full !== (k >= 6) || bus.empty !== 1'b0 || bus.almost_empty !== (k < 2)) begin
                errors++; $display("FAIL fill_flags k=%0d: got af %b e %b ae %b", k, bus.almost_full, bus.empty, bus.almost_empty);
            end
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL fill_state k=%0d: got %b want %b", k, obsv(), expv());
            end
        end
        checks++;
        if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.wr_addr !== 3'd0) begin
            errors++; $display("FAIL fill_end: got count %0d full %b wr %0d want 8 1 0", bus.count, bus.full, bus.wr_addr);
        end
    endtask

    task automatic test_overflow();
        drive(1, 0, 0, 1);
        checks++;
        if (bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL ovf_we: got %b want 0", bus.ram_we);
        end
        tick();
        checks++;
        if (bus.count !== 4'd8 || bus.overflow !== ERR_EN) begin
            errors++; $display("FAIL ovf_flag: got count %0d ovf %b want 8 %b", bus.count, bus.overflow, ERR_EN);
        end
        drive(0, 0, 1, 1);
        tick();
        checks++;
        if (bus.overflow !== ERR_EN || bus.count !== 4'd0 || obsv() !== expv()) begin
            errors++; $display("FAIL ovf_sticky: got %b want %b", obsv(), expv());
        end
    endtask

    task automatic test_simul();
        logic [1:0] want [3];
        int         lvl [3];
        want = '{2'b11, 2'b10, 2'b01};
        lvl  = '{4, 0, 8};
        for (int t = 0; t < 3; t++) begin
            drive(0, 0, 1, 1);
            tick();
            for (int k = 0; k < lvl[t]; k++) begin
                drive(1, 0, 0, 1);
                tick();
            end
            drive(1, 1, 0, 1);
            checks++;
            if ({bus.ram_we, bus.ram_re} !== want[t]) begin
                errors++; $display("FAIL simul_strobes lvl=%0d: got %b want %b", lvl[t], {bus.ram_we, bus.ram_re}, want[t]);
            end
            tick();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL simul_state lvl=%0d: got %b want %b", lvl[t], obsv(), expv());
            end
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1);
            tick();
        end
        for (int k = 0; k < 12; k++) begin
            drive(1, 1, 0, 1);
            tick();
            checks++;
            if (3'(bus.wr_addr - bus.rd_addr) !== 3'd3 || bus.count !== 4'd3 || obsv() !== expv()) begin
                errors++; $display("FAIL wrap k=%0d: got %b want %b", k, obsv(), expv());
            end
        end
    endtask

    task automatic test_flush();
        drive(0, 0, 1, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 1);
            tick();
        end
        drive(1, 1, 1, 1);
        checks++;
        if ({bus.ram_we, bus.ram_re} !== 2'b00) begin
            errors++; $display("FAIL flush_strobes: got %b want 00", {bus.ram_we, bus.ram_re});
        end
        tick();
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.wr_addr !== 3'd0 || bus.rd_addr !== 3'd0) begin
            errors++; $display("FAIL flush_state: got %b want count 0 empty 1 ptrs 0", obsv());
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 1);
            tick();
        end
        drive(1, 0, 0, 0);
        checks++;
        if (bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_we: got %b want 0", bus.ram_we);
        end
        tick();
        checks++;
        if (obsv() !== 16'b0000_0_1_0_1_0_0_000_000) begin
            errors++; $display("FAIL rstmid_state: got %b want %b", obsv(), 16'b0000_0_1_0_1_0_0_000_000);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 59) != 0);
            checks++;
            if ({bus.ram_we, bus.ram_re} !== {exp_we(), exp_re()}) begin
                errors++; $display("FAIL rand_strobes k=%0d: got %b want %b", k, {bus.ram_we, bus.ram_re}, {exp_we(), exp_re()});
            end
            tick();
            checks++;
            if (obsv() !== expv()) begin
                errors++; $display("FAIL rand_state k=%0d: got %b want %b", k, obsv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_simul();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
